// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 pin and scan-code consumer signals for ps2_keyboard_rx.
// slave = receiver side, master = board pins / keyboard-handling logic side.
interface ps2_keyboard_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      input  nextdata_n,
      output data,
      output ready,
      output overflow,
      output frame_err
   );

   modport master (
      output ps2_clk,
      output ps2_data,
      output nextdata_n,
      input  data,
      input  ready,
      input  overflow,
      input  frame_err
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard deframer feeding an 8-entry scan-code FIFO; byte visible 1 clk after the stop-edge detect.
// Full FIFO drops the byte and sets sticky overflow; PS2_PARITY_CHECK_EN adds odd-parity validation.
module ps2_keyboard_rx #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   ps2_keyboard_rx_if.slave   io_bus
);

   localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    r_clk_sync;
   logic [1:0]    r_data_sync;
   logic [3:0]    r_count;
   logic [9:0]    r_buffer;
   logic [TW-1:0] r_to_cnt;
   logic          r_overflow;
   logic          r_frame_err;
   logic [7:0]    r_mem [0:7];
   logic [3:0]    r_wptr;
   logic [3:0]    r_rptr;

   logic w_fall;
   logic w_data;
   logic w_stop;
   logic w_parity_ok;
   logic w_frame_ok;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

`ifdef PS2_PARITY_CHECK_EN
   assign w_parity_ok = ^r_buffer[9:1];
`else
   // parity bit is still captured but never rejects a frame
   assign w_parity_ok = r_buffer[9] | 1'b1;
`endif

   assign w_fall     = r_clk_sync[2] & ~r_clk_sync[1];
   assign w_data     = r_data_sync[1];
   assign w_stop     = w_fall && (r_count == 4'd10);
   assign w_frame_ok = ~r_buffer[0] & w_data & w_parity_ok;
   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = ((r_wptr - r_rptr) == 4'd8);
   assign w_pop      = ~w_empty & ~io_bus.nextdata_n;
   assign w_push     = w_stop & w_frame_ok & (~w_full | w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clk_sync  <= 3'b111;
         r_data_sync <= 2'b11;
      end else begin
         r_clk_sync  <= {r_clk_sync[1:0], io_bus.ps2_clk};
         r_data_sync <= {r_data_sync[0], io_bus.ps2_data};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count     <= 4'd0;
         r_buffer    <= 10'd0;
         r_to_cnt    <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (w_fall) begin
            r_to_cnt <= '0;
            if (r_count == 4'd10) begin
               r_count <= 4'd0;
               if (!w_frame_ok)
                  r_frame_err <= 1'b1;
               else if (w_full && !w_pop)
                  r_overflow <= 1'b1;
            end else begin
               r_buffer[r_count] <= w_data;
               r_count           <= r_count + 4'd1;
            end
         end else if (r_count != 4'd0) begin
            if (r_to_cnt == TO_LAST) begin
               r_count     <= 4'd0;
               r_to_cnt    <= '0;
               r_frame_err <= 1'b1;
            end else begin
               r_to_cnt <= r_to_cnt + TW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= 4'd0;
         r_rptr <= 4'd0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 4'd1;
         if (w_pop)
            r_rptr <= r_rptr + 4'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wptr[2:0]] <= r_buffer[8:1];
   end

   assign io_bus.data      = r_mem[r_rptr[2:0]];
   assign io_bus.ready     = ~w_empty;
   assign io_bus.overflow  = r_overflow;
   assign io_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: framing, parity, overflow, timeout, pop/write collision, reset.
module tb_ps2_keyboard_rx;
   localparam int TO   = 1000;
   localparam int HALF = 8;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   err_cycles;

   ps2_keyboard_rx_if bus ();

   ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.frame_err === 1'b1) err_cycles++;

   task automatic ps2_bit(input logic b);
      bus.ps2_data = b;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_val,
                             input logic pop_at_stop);
      logic [10:0] f;
      f = {stop_val, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 10; i++) ps2_bit(f[i]);
      bus.ps2_data = f[10];
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (pop_at_stop) begin
         repeat (2) @(negedge clk);
         bus.nextdata_n = 1'b0;
         @(negedge clk);
         bus.nextdata_n = 1'b1;
         repeat (HALF - 3) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic pop();
      bus.nextdata_n = 1'b0;
      @(negedge clk);
      bus.nextdata_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL reset_ready got %b want 0", bus.ready); n_fail++; end
      n_checks++; if (bus.overflow !== 1'b0) begin $display("FAIL reset_overflow got %b want 0", bus.overflow); n_fail++; end
      n_checks++; if (bus.frame_err !== 1'b0) begin $display("FAIL reset_frame_err got %b want 0", bus.frame_err); n_fail++; end
   endtask

   task automatic test_single_byte();
      int e0;
      e0 = err_cycles;
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      n_checks++; if (bus.ready !== 1'b1) begin $display("FAIL single_ready got %b want 1", bus.ready); n_fail++; end
      n_checks++; if (bus.data !== 8'h1C) begin $display("FAIL single_data got %h want 1c", bus.data); n_fail++; end
      n_checks++; if (err_cycles - e0 !== 0) begin $display("FAIL single_err got %0d want 0", err_cycles - e0); n_fail++; end
      pop();
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL single_pop_ready got %b want 0", bus.ready); n_fail++; end
      pop();
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL empty_pop_ready got %b want 0", bus.ready); n_fail++; end
   endtask

   task automatic test_parity_error();
      int e0;
      e0 = err_cycles;
      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      n_checks++; if (err_cycles - e0 !== 1) begin $display("FAIL parity_err got %0d want 1", err_cycles - e0); n_fail++; end
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL parity_ready got %b want 0", bus.ready); n_fail++; end
`else
      n_checks++; if (err_cycles - e0 !== 0) begin $display("FAIL parity_err got %0d want 0", err_cycles - e0); n_fail++; end
      n_checks++; if (bus.ready !== 1'b1) begin $display("FAIL parity_ready got %b want 1", bus.ready); n_fail++; end
      n_checks++; if (bus.data !== 8'hF0) begin $display("FAIL parity_data got %h want f0", bus.data); n_fail++; end
      pop();
`endif
   endtask

   task automatic test_framing();
      int e0;
      e0 = err_cycles;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      n_checks++; if (err_cycles - e0 !== 1) begin $display("FAIL bad_stop_err got %0d want 1", err_cycles - e0); n_fail++; end
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL bad_stop_ready got %b want 0", bus.ready); n_fail++; end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      n_checks++; if (bus.overflow !== 1'b0) begin $display("FAIL ovf_before got %b want 0", bus.overflow); n_fail++; end
      send_frame(8'h09, 1'b0, 1'b1, 1'b0);
      n_checks++; if (bus.overflow !== 1'b1) begin $display("FAIL ovf_after got %b want 1", bus.overflow); n_fail++; end
      for (int i = 1; i <= 8; i++) begin
         n_checks++;
         if (bus.data !== 8'(i)) begin $display("FAIL ovf_pop%0d got %h want %h", i, bus.data, 8'(i)); n_fail++; end
         pop();
      end
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL ovf_drain_ready got %b want 0", bus.ready); n_fail++; end
   endtask

   task automatic test_timeout();
      int e0;
      e0 = err_cycles;
      for (int i = 0; i < 5; i++) ps2_bit(1'b0);
      repeat (TO + 10) @(negedge clk);
      n_checks++; if (err_cycles - e0 !== 1) begin $display("FAIL timeout_err got %0d want 1", err_cycles - e0); n_fail++; end
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      n_checks++; if (bus.ready !== 1'b1) begin $display("FAIL timeout_next_ready got %b want 1", bus.ready); n_fail++; end
      n_checks++; if (bus.data !== 8'h5A) begin $display("FAIL timeout_next_data got %h want 5a", bus.data); n_fail++; end
      n_checks++; if (err_cycles - e0 !== 1) begin $display("FAIL timeout_next_err got %0d want 1", err_cycles - e0); n_fail++; end
      pop();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
      send_frame(8'h33, 1'b0, 1'b1, 1'b1);
      n_checks++; if (bus.overflow !== 1'b0) begin $display("FAIL collide_ovf got %b want 0", bus.overflow); n_fail++; end
      for (int i = 1; i < 8; i++) begin
         n_checks++;
         if (bus.data !== 8'h10 + 8'(i)) begin $display("FAIL collide_pop%0d got %h want %h", i, bus.data, 8'h10 + 8'(i)); n_fail++; end
         pop();
      end
      n_checks++; if (bus.data !== 8'h33) begin $display("FAIL collide_last got %h want 33", bus.data); n_fail++; end
      pop();
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL collide_drain_ready got %b want 0", bus.ready); n_fail++; end
   endtask

   task automatic test_reset_midframe();
      int e0;
      for (int i = 0; i < 9; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b1, 1'b0);
      n_checks++; if (bus.overflow !== 1'b1) begin $display("FAIL mid_pre_ovf got %b want 1", bus.overflow); n_fail++; end
      for (int i = 0; i < 4; i++) ps2_bit(1'b0);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.ready !== 1'b0) begin $display("FAIL mid_rst_ready got %b want 0", bus.ready); n_fail++; end
      n_checks++; if (bus.overflow !== 1'b0) begin $display("FAIL mid_rst_ovf got %b want 0", bus.overflow); n_fail++; end
      n_checks++; if (bus.frame_err !== 1'b0) begin $display("FAIL mid_rst_err got %b want 0", bus.frame_err); n_fail++; end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      e0 = err_cycles;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      n_checks++; if (bus.ready !== 1'b1) begin $display("FAIL mid_next_ready got %b want 1", bus.ready); n_fail++; end
      n_checks++; if (bus.data !== 8'hA5) begin $display("FAIL mid_next_data got %h want a5", bus.data); n_fail++; end
      n_checks++; if (err_cycles - e0 !== 0) begin $display("FAIL mid_next_err got %0d want 0", err_cycles - e0); n_fail++; end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      err_cycles     = 0;
      rst            = 1'b1;
      bus.ps2_clk    = 1'b1;
      bus.ps2_data   = 1'b1;
      bus.nextdata_n = 1'b1;
      test_reset();
      test_single_byte();
      test_parity_error();
      test_framing();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
